// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer
//   Instruction fetch/decode/execute sequencer that drives the register bank
//   (write select/LE, read selects SBA/SBB) and the ALU controls. Owns the PC.
// Ports
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   instr_req/addr   : fetch request (held until instr_valid) and fetch address (= pc)
//   instr_valid/data : instruction return; ignored unless instr_req is high
//   alu_zero         : ALU zero flag for the operands currently on SBA/SBB
//   select, LE       : bank write index and one-cycle write enable
//   SBA, SBB         : bank read indices
//   alu_op, src_imm  : ALU operation and write-data source (1 = imm)
//   imm              : low byte of the current instruction
//   pc, halted       : program counter and HALT indication
module reg_bank_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [15:0]     instr_data,
    input  logic            alu_zero,
    output logic [3:0]      select,
    output logic            LE,
    output logic [3:0]      SBA,
    output logic [3:0]      SBB,
    output logic [2:0]      alu_op,
    output logic            src_imm,
    output logic [7:0]      imm,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned IMM_W   = 8;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'd4;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               req_q, req_d;
    logic               le_q, le_d;
    logic [REG_W-1:0]   sel_q, sel_d;
    logic [REG_W-1:0]   sba_q, sba_d;
    logic [REG_W-1:0]   sbb_q, sbb_d;
    logic [ALU_W-1:0]   aluop_q, aluop_d;
    logic               srcimm_q, srcimm_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               halted_q, halted_d;

    // ALU operation implied by an opcode; everything else passes A through
    function automatic logic [ALU_W-1:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_ADD:  alu_op_of = ALU_ADD;
            OP_SUB:  alu_op_of = ALU_SUB;
            OP_AND:  alu_op_of = ALU_AND;
            OP_OR:   alu_op_of = ALU_OR;
            default: alu_op_of = ALU_PASS;
        endcase
    endfunction

    // Opcodes that write rd; illegal opcodes 9..E behave as NOP
    function automatic logic writes_rd(input logic [3:0] op);
        writes_rd = (op == OP_LDI) || (op == OP_MOV) || (op == OP_ADD) ||
                    (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            req_q    <= 1'b0;
            le_q     <= 1'b0;
            sel_q    <= '0;
            sba_q    <= '0;
            sbb_q    <= '0;
            aluop_q  <= '0;
            srcimm_q <= 1'b0;
            imm_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            le_q     <= le_d;
            sel_q    <= sel_d;
            sba_q    <= sba_d;
            sbb_q    <= sbb_d;
            aluop_q  <= aluop_d;
            srcimm_q <= srcimm_d;
            imm_q    <= imm_d;
            halted_q <= halted_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_d    = req_q;
        le_d     = 1'b0;
        sel_d    = sel_q;
        sba_d    = sba_q;
        sbb_d    = sbb_q;
        aluop_d  = aluop_q;
        srcimm_d = srcimm_q;
        imm_d    = imm_q;
        halted_d = halted_q;

        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                // Accept only against a request already visible to memory
                if (req_q && instr_valid) begin
                    state_d  = ST_DECODE;
                    req_d    = 1'b0;
                    ir_d     = instr_data;
                    sba_d    = instr_data[7:4];
                    sbb_d    = instr_data[3:0];
                    imm_d    = instr_data[7:0];
                    aluop_d  = alu_op_of(instr_data[15:12]);
                    srcimm_d = (instr_data[15:12] == OP_LDI);
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
                if (writes_rd(ir_q[15:12])) begin
                    sel_d = ir_q[11:8];
                    le_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                case (ir_q[15:12])
                    OP_JMP: pc_d = PC_W'(ir_q[7:0]);
                    OP_JZ: begin
                        if (alu_zero) begin
                            pc_d = PC_W'(ir_q[7:0]);
                        end
                    end
                    OP_HALT: begin
                        pc_d     = pc_q;
                        state_d  = ST_HALT;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                req_d    = 1'b0;
                halted_d = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign instr_req  = req_q;
    assign instr_addr = pc_q;
    assign select     = sel_q;
    assign LE         = le_q;
    assign SBA        = sba_q;
    assign SBB        = sbb_q;
    assign alu_op     = aluop_q;
    assign src_imm    = srcimm_q;
    assign imm        = imm_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// tb_reg_bank_sequencer
//   Directed plus randomized bench for reg_bank_sequencer. A behavioural model
//   (register array, PC, per-opcode effects) predicts each instruction's outputs.
module tb_reg_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        alu_zero;
    logic [3:0]  select;
    logic        LE;
    logic [3:0]  SBA;
    logic [3:0]  SBB;
    logic [2:0]  alu_op;
    logic        src_imm;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] regs [16];
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    reg_bank_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .alu_zero    (alu_zero),
        .select      (select),
        .LE          (LE),
        .SBA         (SBA),
        .SBB         (SBB),
        .alu_op      (alu_op),
        .src_imm     (src_imm),
        .imm         (imm),
        .pc          (pc),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Assert reset, check reset values, release; returns at the negedge after
    // the first clock edge, where instr_req must be high.
    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        alu_zero    = 1'b0;
        #1;
        chk("rst_req", instr_req, 0);
        chk("rst_le", LE, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_sel", select, 0);
        chk("rst_sba", SBA, 0);
        chk("rst_sbb", SBB, 0);
        chk("rst_aluop", alu_op, 0);
        chk("rst_srcimm", src_imm, 0);
        chk("rst_imm", imm, 0);
        @(negedge clk);
        // valid offered before any request must be ignored
        instr_valid = 1'b1;
        instr_data  = 16'h1FFF;
        rst_n       = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rel_sba_untouched", SBA, 0);
        exp_pc = 8'h00;
    endtask

    // Run one instruction through fetch (with lat wait cycles), decode, exec.
    // Entered and left at a negedge where the sequencer is in FETCH (or HALT).
    task automatic do_instr(input logic [15:0] ins, input int lat);
        logic [3:0] op, rd, ra, rb;
        logic [7:0] im;
        logic       wr, zf, hlt;
        logic [2:0] aop;
        op  = ins[15:12];
        rd  = ins[11:8];
        ra  = ins[7:4];
        rb  = ins[3:0];
        im  = ins[7:0];
        wr  = (op >= 4'd1) && (op <= 4'd6);
        aop = ((op >= 4'd3) && (op <= 4'd6)) ? 3'(op - 4'd2) : 3'd0;
        hlt = (op == 4'hF);

        chk("fetch_req", instr_req, 1);
        chk("fetch_addr", instr_addr, exp_pc);
        chk("fetch_le", LE, 0);
        for (int i = 0; i < lat; i++) begin
            instr_valid = 1'b0;
            instr_data  = 16'($urandom);
            @(negedge clk);
            chk("wait_req", instr_req, 1);
            chk("wait_addr", instr_addr, exp_pc);
            chk("wait_le", LE, 0);
        end
        instr_valid = 1'b1;
        instr_data  = ins;
        @(negedge clk);

        // decode cycle: stray valid/data must be ignored
        instr_valid = 1'($urandom_range(0, 1));
        instr_data  = 16'($urandom);
        chk("dec_req", instr_req, 0);
        chk("dec_le", LE, 0);
        chk("dec_sba", SBA, ra);
        chk("dec_sbb", SBB, rb);
        chk("dec_aluop", alu_op, aop);
        chk("dec_srcimm", src_imm, (op == 4'd1));
        chk("dec_imm", imm, im);
        @(negedge clk);

        // exec cycle
        zf = (op == 4'd8) ? (regs[ra] == 8'h00) : 1'($urandom_range(0, 1));
        alu_zero = zf;
        chk("exec_le", LE, wr);
        if (wr) chk("exec_sel", select, rd);
        chk("exec_sba", SBA, ra);
        chk("exec_sbb", SBB, rb);
        chk("exec_aluop", alu_op, aop);
        chk("exec_srcimm", src_imm, (op == 4'd1));
        chk("exec_pc", pc, exp_pc);
        chk("exec_req", instr_req, 0);

        case (op)
            4'd1: regs[rd] = im;
            4'd2: regs[rd] = regs[ra];
            4'd3: regs[rd] = regs[ra] + regs[rb];
            4'd4: regs[rd] = regs[ra] - regs[rb];
            4'd5: regs[rd] = regs[ra] & regs[rb];
            4'd6: regs[rd] = regs[ra] | regs[rb];
            default: ;
        endcase
        if (op == 4'd7)              exp_pc = im;
        else if (op == 4'd8 && zf)   exp_pc = im;
        else if (!hlt)               exp_pc = exp_pc + 8'd1;
        @(negedge clk);
        instr_valid = 1'b0;

        chk("post_pc", pc, exp_pc);
        chk("post_le", LE, 0);
        chk("post_req", instr_req, !hlt);
        chk("post_halted", halted, hlt);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        instr_data = 16'h0000;
        exp_pc     = 8'h00;

        do_reset();

        // LDI r3,0x5A answered in the request cycle
        do_instr(16'h135A, 0);

        // LDI r1,7; LDI r2,7; SUB r4,r1,r2
        do_instr(16'h1107, 0);
        do_instr(16'h1207, 1);
        do_instr(16'h4412, 0);

        // JZ on r4 (zero) to 0x40, then r4 nonzero -> fall through
        do_instr(16'h8040, 0);
        do_instr(16'h1401, 0);
        do_instr(16'h8040, 2);

        // Slow memory: request held 6 cycles
        do_instr(16'h2630, 5);

        // PC wrap and illegal opcode
        do_instr(16'h70FF, 0);
        do_instr(16'h0000, 0);
        do_instr(16'hB123, 1);

        // Randomized program (no HALT)
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  rop;
            logic [15:0] rins;
            rop  = 4'($urandom_range(0, 14));
            rins = {rop, 12'($urandom)};
            do_instr(rins, int'($urandom_range(0, 3)));
        end

        // HALT is absorbing even with valid pulses
        do_instr(16'hF000, 0);
        for (int i = 0; i < 4; i++) begin
            instr_valid = 1'b1;
            instr_data  = 16'h1155;
            @(negedge clk);
            chk("halt_halted", halted, 1);
            chk("halt_pc", pc, exp_pc);
            chk("halt_req", instr_req, 0);
            chk("halt_le", LE, 0);
        end
        instr_valid = 1'b0;

        // Reset in the middle of ADD's exec cycle
        do_reset();
        chk("abort_fetch_req", instr_req, 1);
        instr_valid = 1'b1;
        instr_data  = 16'h3512;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_le", LE, 1);
        chk("abort_pre_sel", select, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_le", LE, 0);
        chk("abort_pc", pc, 0);
        chk("abort_req", instr_req, 0);
        chk("abort_sel", select, 0);
        @(negedge clk);
        chk("abort_le_held", LE, 0);

        // Restart cleanly after the abort
        do_reset();
        do_instr(16'h1A55, 0);
        do_instr(16'h0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
